// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesting agents (master) and rr_grant_arbiter (slave).
// IDXW follows the arbiter's grant-index width rule: max(1, clog2(N)).
interface rr_grant_arbiter_if #(
  parameter int N    = 4,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [IDXW-1:0] gnt_idx;
  logic            preempt;

  modport master (
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_idx,
    input  preempt
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_idx,
    output preempt
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: registered one-hot grant held until release, rotating priority pointer.
// Define RR_ARB_HOLD_LIMIT_EN to compile in the MAX_HOLD hold limit with forced rotation (preempt).
module rr_grant_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_grant_arbiter_if.slave bus
);

  localparam int              IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW:0]   N_W  = (IDXW + 1)'(N);

  if (N < 1) begin : g_bad_n
    $error("rr_grant_arbiter: N must be at least 1");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("rr_grant_arbiter: MAX_HOLD must be at least 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [IDXW-1:0] ptr_reg, ptr_next;
  logic [IDXW-1:0] idx_reg, idx_next;
  logic [N-1:0]    gnt_reg, gnt_next;
  logic [IDXW-1:0] succ;
  logic [N-1:0]    others;
  logic            released;

  // (v + 1) mod N, computed one bit wider so N-1 wraps to 0 for any N.
  function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] v);
    logic [IDXW:0] s;
    s = {1'b0, v} + (IDXW + 1)'(1);
    if (s >= N_W) begin
      s = '0;
    end
    return s[IDXW-1:0];
  endfunction

  // First set bit of mask scanning p, p+1, ..., N-1, 0, ..., p-1 (mask must be nonzero).
  function automatic logic [IDXW-1:0] pick(input logic [N-1:0] mask, input logic [IDXW-1:0] p);
    logic [2*N-1:0] dbl;
    logic [IDXW:0]  s;
    dbl = {mask, mask} >> p;
    s   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        s = (IDXW + 1)'(i);
      end
    end
    s = s + {1'b0, p};
    if (s >= N_W) begin
      s = s - N_W;
    end
    return s[IDXW-1:0];
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] v);
    return N'(1) << v;
  endfunction

  assign succ     = wrap_inc(idx_reg);
  assign others   = bus.req & ~gnt_reg;
  assign released = ~|(bus.req & gnt_reg);

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int            HCW        = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] MAX_HOLD_W = HCW'(MAX_HOLD);

  logic [HCW-1:0] hold_cnt_reg, hold_cnt_next;
  logic           preempt_reg, preempt_next;
`endif

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    idx_next   = idx_reg;
    gnt_next   = gnt_reg;
`ifdef RR_ARB_HOLD_LIMIT_EN
    hold_cnt_next = hold_cnt_reg;
    preempt_next  = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (|bus.req) begin
          idx_next   = pick(bus.req, ptr_reg);
          gnt_next   = onehot(idx_next);
          state_next = BUSY;
`ifdef RR_ARB_HOLD_LIMIT_EN
          hold_cnt_next = HCW'(1);
`endif
        end
      end
      BUSY: begin
        if (released) begin
          // Hand off on the same edge when anyone else is waiting.
          ptr_next = succ;
          if (|bus.req) begin
            idx_next = pick(bus.req, succ);
            gnt_next = onehot(idx_next);
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_cnt_next = HCW'(1);
`endif
          end else begin
            idx_next   = '0;
            gnt_next   = '0;
            state_next = IDLE;
          end
        end else begin
`ifdef RR_ARB_HOLD_LIMIT_EN
          if ((hold_cnt_reg == MAX_HOLD_W) && (|others)) begin
            ptr_next      = succ;
            idx_next      = pick(others, succ);
            gnt_next      = onehot(idx_next);
            hold_cnt_next = HCW'(1);
            preempt_next  = 1'b1;
          end else if (hold_cnt_reg != MAX_HOLD_W) begin
            hold_cnt_next = hold_cnt_reg + HCW'(1);
          end
`endif
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      idx_reg   <= '0;
      gnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
      gnt_reg   <= gnt_next;
    end
  end

`ifdef RR_ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_reg <= '0;
      preempt_reg  <= 1'b0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      preempt_reg  <= preempt_next;
    end
  end

  assign bus.preempt = preempt_reg;
`else
  // Without the hold limit the grant only moves on release.
  assign bus.preempt = 1'b0;
`endif

  assign bus.gnt       = gnt_reg;
  assign bus.gnt_valid = |gnt_reg;
  assign bus.gnt_idx   = idx_reg;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed table plus randomized run of rr_grant_arbiter (N=4/MAX_HOLD=4 and N=5/MAX_HOLD=3)
// against a rule-level round-robin reference model.
module tb_rr_grant_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_grant_arbiter_if #(.N(4)) bus4 ();
  rr_grant_arbiter_if #(.N(5)) bus5 ();

  rr_grant_arbiter #(.N(4), .MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  rr_grant_arbiter #(.N(5), .MAX_HOLD(3)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));

  int checks = 0;
  int errors = 0;

  // Reference model: grantee -1 means idle.
  int m_n[2]  = '{4, 5};
  int m_mh[2] = '{4, 3};
  int m_ptr[2];
  int m_g[2];
  int m_hold[2];
  int m_pre[2];

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    int         idx;
    logic       pre;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mkv(logic [3:0] r, logic [3:0] g, int i, logic p);
    vec_t v;
    v.req = r; v.gnt = g; v.idx = i; v.pre = p;
    return v;
  endfunction

  function automatic int first_set(int mask, int p, int n);
    for (int k = 0; k < n; k++) begin
      if (((mask >> ((p + k) % n)) & 1) != 0) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_g[d] = -1; m_hold[d] = 0; m_pre[d] = 0;
    end
  endtask

  task automatic model_step(int d, int req);
    int n = m_n[d];
    int g = m_g[d];
    m_pre[d] = 0;
    if (g < 0) begin
      if (req != 0) begin
        m_g[d] = first_set(req, m_ptr[d], n);
        m_hold[d] = 1;
      end
    end else if (((req >> g) & 1) == 0) begin
      m_ptr[d] = (g + 1) % n;
      if (req != 0) begin
        m_g[d] = first_set(req, m_ptr[d], n);
        m_hold[d] = 1;
      end else begin
        m_g[d] = -1;
      end
    end else begin
`ifdef RR_ARB_HOLD_LIMIT_EN
      if (m_hold[d] == m_mh[d] && (req & ~(1 << g)) != 0) begin
        m_ptr[d]  = (g + 1) % n;
        m_g[d]    = first_set(req & ~(1 << g), m_ptr[d], n);
        m_hold[d] = 1;
        m_pre[d]  = 1;
      end else if (m_hold[d] < m_mh[d]) begin
        m_hold[d] = m_hold[d] + 1;
      end
`endif
    end
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_dut(int d, string tag, int eg, int ei, int ep);
    int ag, ai, av, ap;
    if (d == 0) begin
      ag = int'(bus4.gnt); ai = int'(bus4.gnt_idx); av = int'(bus4.gnt_valid); ap = int'(bus4.preempt);
    end else begin
      ag = int'(bus5.gnt); ai = int'(bus5.gnt_idx); av = int'(bus5.gnt_valid); ap = int'(bus5.preempt);
    end
    check({tag, "_gnt"}, ag, eg);
    check({tag, "_idx"}, ai, ei);
    check({tag, "_valid"}, av, (eg != 0) ? 1 : 0);
    check({tag, "_preempt"}, ap, ep);
  endtask

  task automatic check_model(int d, string tag);
    int eg;
    eg = (m_g[d] < 0) ? 0 : (1 << m_g[d]);
    check_dut(d, tag, eg, (m_g[d] < 0) ? 0 : m_g[d], m_pre[d]);
  endtask

  // Apply requests on the falling edge, advance the model on the rising edge, sample 1 ns later.
  task automatic tick(int r4, int r5);
    @(negedge clk);
    bus4.req = 4'(r4);
    bus5.req = 5'(r5);
    @(posedge clk);
    model_step(0, r4);
    model_step(1, r5);
    #1;
  endtask

  task automatic pulse_reset(string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_dut(0, {tag, "_n4"}, 0, 0, 0);
    check_dut(1, {tag, "_n5"}, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int r4, r5;

    tbl[0]  = mkv(4'b0101, 4'b0001, 0, 1'b0);
    tbl[1]  = mkv(4'b0100, 4'b0100, 2, 1'b0);
    tbl[2]  = mkv(4'b0000, 4'b0000, 0, 1'b0);
    tbl[3]  = mkv(4'b1111, 4'b1000, 3, 1'b0);
    tbl[4]  = mkv(4'b0111, 4'b0001, 0, 1'b0);
    tbl[5]  = mkv(4'b0110, 4'b0010, 1, 1'b0);
    tbl[6]  = mkv(4'b0100, 4'b0100, 2, 1'b0);
    tbl[7]  = mkv(4'b0000, 4'b0000, 0, 1'b0);
    tbl[8]  = mkv(4'b0001, 4'b0001, 0, 1'b0);
    tbl[9]  = mkv(4'b0001, 4'b0001, 0, 1'b0);
    tbl[10] = mkv(4'b0011, 4'b0001, 0, 1'b0);
    tbl[11] = mkv(4'b0011, 4'b0001, 0, 1'b0);
`ifdef RR_ARB_HOLD_LIMIT_EN
    tbl[12] = mkv(4'b0011, 4'b0010, 1, 1'b1);
    tbl[13] = mkv(4'b0011, 4'b0010, 1, 1'b0);
    tbl[14] = mkv(4'b0011, 4'b0010, 1, 1'b0);
`else
    tbl[12] = mkv(4'b0011, 4'b0001, 0, 1'b0);
    tbl[13] = mkv(4'b0011, 4'b0001, 0, 1'b0);
    tbl[14] = mkv(4'b0011, 4'b0001, 0, 1'b0);
`endif
    tbl[15] = mkv(4'b0000, 4'b0000, 0, 1'b0);

    rst_n    = 1'b0;
    bus4.req = 4'b0000;
    bus5.req = 5'b00000;
    model_reset();
    #2;
    check_dut(0, "reset_n4", 0, 0, 0);
    check_dut(1, "reset_n5", 0, 0, 0);

    // Requests during reset must not be granted.
    bus4.req = 4'b0101;
    @(posedge clk);
    #1;
    check_dut(0, "reset_req_n4", 0, 0, 0);
    @(negedge clk);
    bus4.req = 4'b0000;
    rst_n    = 1'b1;

    foreach (tbl[i]) begin
      tick(int'(tbl[i].req), 0);
      $display("row %0d: req=%b gnt=%b idx=%0d preempt=%0d", i, bus4.req, bus4.gnt, bus4.gnt_idx, bus4.preempt);
      check_dut(0, $sformatf("row%0d", i), int'(tbl[i].gnt), tbl[i].idx, int'(tbl[i].pre));
    end

    // Reset mid-grant clears immediately; the next scan starts from index 0.
    tick(4'b0100, 0);
    check_dut(0, "busy_before_reset", 4'b0100, 2, 0);
    pulse_reset("async_reset");
    tick(4'b0110, 0);
    $display("post-reset: req=%b gnt=%b idx=%0d", bus4.req, bus4.gnt, bus4.gnt_idx);
    check_dut(0, "scan_from_zero", 4'b0010, 1, 0);
    tick(0, 0);

    // N=5 pointer wrap: 4 -> 0, never 5.
    tick(0, 5'b01000);
    check_dut(1, "n5_grant3", 5'b01000, 3, 0);
    tick(0, 5'b00000);
    check_dut(1, "n5_idle", 0, 0, 0);
    tick(0, 5'b00011);
    check_dut(1, "n5_ptr4_wrap", 5'b00001, 0, 0);
    tick(0, 5'b10010);
    check_dut(1, "n5_handoff1", 5'b00010, 1, 0);
    tick(0, 5'b10000);
    check_dut(1, "n5_grant4", 5'b10000, 4, 0);
    tick(0, 5'b00001);
    check_dut(1, "n5_wrap_after4", 5'b00001, 0, 0);
    $display("n5 wrap: req=%b gnt=%b idx=%0d", bus5.req, bus5.gnt, bus5.gnt_idx);
    tick(0, 0);

    // Randomized run: each request bit toggles occasionally so grants are held for several cycles.
    r4 = 0;
    r5 = 0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) r4 = r4 ^ (1 << b);
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 5) == 0) r5 = r5 ^ (1 << b);
      tick(r4, r5);
      $display("rnd %0d: req4=%b gnt4=%b pre4=%0d req5=%b gnt5=%b pre5=%0d",
               c, bus4.req, bus4.gnt, bus4.preempt, bus5.req, bus5.gnt, bus5.preempt);
      check_model(0, $sformatf("rnd%0d_n4", c));
      check_model(1, $sformatf("rnd%0d_n5", c));
      if ($urandom_range(0, 149) == 0) begin
        pulse_reset($sformatf("rnd%0d_reset", c));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
